piso_bit_serializer: RTL and testbench
======================================

Name: piso_bit_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the Moore sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on dout, which drives the detector's din.
- Supports back-to-back words with no idle bit, so bit patterns can straddle word boundaries.
- dout_valid tells downstream logic and the bench which cycles carry real data.

Parameters:
- WIDTH, 8, data bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = in_data[WIDTH-1] sent first; 0 = in_data[0] sent first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- in_data  input  WIDTH  parallel word, sampled on the accepting edge only.
- in_valid  input  1  upstream has a word.
- in_ready  output  1  serializer can take a word this cycle.
- dout  output  1  serial bit to the detector's din.
- dout_valid  output  1  dout carries a data bit this cycle.
- busy  output  1  a word is in flight (state SHIFT).

Behaviour:
- Reset (rst=0): state=IDLE, shift register=0, bit_cnt=0, dout=0, dout_valid=0, busy=0.
- Reset values hold while rst=0. In-flight bits are discarded, not resumed.
- in_ready is combinational from state/bit_cnt only, never from in_valid:
  - 1 in IDLE.
  - 1 in SHIFT on the frame's last bit cycle.
  - 0 otherwise.
- Accept occurs at an edge where in_valid=1 and in_ready=1. in_data is loaded into the shift register and bit_cnt=0.
- States:
  - IDLE:
    - dout=0, dout_valid=0, busy=0.
    - On accept, go to SHIFT. The first bit is presented on dout after that same edge.
  - SHIFT:
    - dout = current bit, dout_valid=1, busy=1.
    - Each edge advances one bit and increments bit_cnt.
  - Last bit cycle (bit_cnt = FRAME_LEN-1):
    - If accept: load the new word, stay in SHIFT, bit_cnt=0. No gap bit.
    - Else: go to IDLE.
- FRAME_LEN = WIDTH, or WIDTH+1 with the optional feature.
- Latency: accept edge N. Bit k is on dout during the cycle following edge N+k.
- dout and dout_valid are registered (no combinational path from inputs).
- bit_cnt width is clog2(WIDTH+1). Wrap is never relied on; the counter is reloaded explicitly.
- in_valid=1 while not ready: the word is not sampled. Upstream must hold in_data/in_valid stable until accepted (no drop, no duplicate).
- in_valid falling before acceptance: no effect.
- Async reset asserted mid-word: dout drops to 0 without waiting for a clock. After release, the first edge with in_valid=1 accepts a fresh word.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra bit is sent = XOR of all WIDTH data bits (even parity), with dout_valid=1.
  - FRAME_LEN = WIDTH+1. in_ready rises on the parity cycle instead of the last data bit.
- Undefined: no parity bit, FRAME_LEN = WIDTH, and no parity logic is present in the netlist.

Test Plan:
1. Reset and single word:
   - Stimulus: WIDTH=4, MSB_FIRST=1, rst=0 for 10ns then 1; in_data=4'b1011, in_valid for one accept.
   - Required: dout = 1,0,1,1 on 4 consecutive cycles with dout_valid=1; busy=1 for exactly 4 cycles; then dout=0, dout_valid=0.
   - Downstream detector asserts y once.
2. Back-to-back words:
   - Stimulus: 4'b0101 then 4'b1011, in_valid held high.
   - Required: 8 contiguous valid bits 0,1,0,1,1,0,1,1 with no dout_valid gap; second accept coincides with the last bit of word 1.
3. Stall:
   - Stimulus: in_valid=1 with 4'b1110 while 4'b0001 is shifting.
   - Required: in_ready=0 for the first 3 bit cycles; 4'b1110 accepted only on bit 4; output sequence 0,0,0,1,1,1,1,0.
4. LSB first:
   - Stimulus: MSB_FIRST=0, in_data=4'b1101.
   - Required: dout = 1,0,1,1.
5. Async reset mid-word:
   - Stimulus: rst=0 asserted between clock edges after 2 bits of 4'b1011.
   - Required: dout=0, dout_valid=0, busy=0 immediately; no remaining bits after release; next word starts cleanly from bit 0.
6. Parity (PISO_PARITY_EN defined, WIDTH=4):
   - Stimulus: 4'b1011, then 4'b1001.
   - Required: dout = 1,0,1,1,1 then 1,0,0,1,0; each frame 5 valid cycles; in_ready high on parity cycles only.

Source files
------------

// File: rtl/piso_bit_serializer.sv
// -----------------------------------------------------------------------------
// piso_bit_serializer
//
// Parallel-in / serial-out stage feeding the sequence detector's din. Words of
// WIDTH bits are taken over a valid/ready handshake and shifted out one bit per
// clock. A new word can be accepted on the last bit cycle of the current frame,
// so consecutive frames are emitted with no idle bit between them.
//
// Optional feature (compile-time macro PISO_PARITY_EN):
//   when defined, each frame carries one extra trailing bit equal to the XOR of
//   the WIDTH data bits (even parity). When undefined, no parity logic exists.
//
// Parameters:
//   WIDTH      data bits per word (2..32)
//   MSB_FIRST  1: in_data[WIDTH-1] is sent first, 0: in_data[0] is sent first
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   in_data     parallel word, sampled only on the accepting edge
//   in_valid    upstream offers a word
//   in_ready    serializer can take a word this cycle (state/counter only)
//   dout        serial data bit (registered)
//   dout_valid  dout carries a frame bit this cycle (registered)
//   busy        a frame is in flight (registered)
// -----------------------------------------------------------------------------
module piso_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e               state_q;
    logic [FRAME_LEN-1:0] shreg_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic                 dout_valid_q;
    logic                 busy_q;

    logic [FRAME_LEN-1:0] frame_d;
    logic [FRAME_LEN-1:0] shreg_d;
    logic [CNT_W-1:0]     bit_cnt_d;
    logic                 last_bit;
    logic                 accept;

    // Whole frame image loaded on accept. The outgoing bit always sits at the
    // end of the register that dout taps, so shifting just moves the next bit in.
    always_comb begin
        frame_d = '0;
`ifdef PISO_PARITY_EN
        if (MSB_FIRST) begin
            frame_d = {in_data, ^in_data};
        end else begin
            frame_d = {^in_data, in_data};
        end
`else
        frame_d = in_data;
`endif
        shreg_d   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end

    assign last_bit = (state_q == SHIFT) && (bit_cnt_q == LAST_CNT);
    assign in_ready = (state_q == IDLE) || last_bit;
    assign accept   = in_valid && in_ready;

    // The register is cleared on every return to IDLE, so tapping it directly
    // gives dout=0 whenever no frame is in flight while staying a flop output.
    assign dout       = MSB_FIRST ? shreg_q[FRAME_LEN-1] : shreg_q[0];
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q      <= SHIFT;
                        shreg_q      <= frame_d;
                        bit_cnt_q    <= '0;
                        dout_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        if (accept) begin
                            // Back-to-back reload: no gap bit between frames.
                            state_q      <= SHIFT;
                            shreg_q      <= frame_d;
                            bit_cnt_q    <= '0;
                            dout_valid_q <= 1'b1;
                            busy_q       <= 1'b1;
                        end else begin
                            state_q      <= IDLE;
                            shreg_q      <= '0;
                            bit_cnt_q    <= '0;
                            dout_valid_q <= 1'b0;
                            busy_q       <= 1'b0;
                        end
                    end else begin
                        shreg_q   <= shreg_d;
                        bit_cnt_q <= bit_cnt_d;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    shreg_q      <= '0;
                    bit_cnt_q    <= '0;
                    dout_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_bit_serializer
//
// Drives two WIDTH=4 serializers (MSB-first and LSB-first) with the same
// handshake and compares both against a reference built from queues of the
// bits each frame should still present: the queue head is the bit expected on
// dout, an empty queue means idle, and a word may be taken when at most one
// bit is left. Directed cases come first, then randomized traffic.
// Honours PISO_PARITY_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_piso_bit_serializer;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;

    logic m_ready, m_dout, m_valid, m_busy;
    logic l_ready, l_dout, l_valid, l_busy;

    int checks;
    int errors;
    bit accepted;

    bit qm[$];
    bit ql[$];

    piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (m_ready),
        .dout      (m_dout),
        .dout_valid(m_valid),
        .busy      (m_busy)
    );

    piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (l_ready),
        .dout      (l_dout),
        .dout_valid(l_valid),
        .busy      (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Append the bits of one frame in transmission order.
    task automatic push_frame(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            qm.push_back(w[W-1-i]);
            ql.push_back(w[i]);
        end
`ifdef PISO_PARITY_EN
        qm.push_back(^w);
        ql.push_back(^w);
`endif
    endtask

    task automatic compare();
        logic em_v, el_v;
        em_v = (qm.size() > 0);
        el_v = (ql.size() > 0);
        check("m_dout",  m_dout,  em_v ? qm[0] : 1'b0);
        check("m_valid", m_valid, em_v);
        check("m_busy",  m_busy,  em_v);
        check("m_ready", m_ready, qm.size() <= 1);
        check("l_dout",  l_dout,  el_v ? ql[0] : 1'b0);
        check("l_valid", l_valid, el_v);
        check("l_busy",  l_busy,  el_v);
        check("l_ready", l_ready, ql.size() <= 1);
    endtask

    // One clock: advance the reference with the inputs seen at the edge,
    // then check the outputs shortly after the edge.
    task automatic step();
        bit acc;
        @(posedge clk);
        acc = 1'b0;
        if (rst) begin
            acc = in_valid && (qm.size() <= 1);
            if (qm.size() > 0) void'(qm.pop_front());
            if (ql.size() > 0) void'(ql.pop_front());
            if (acc) push_frame(in_data);
        end
        accepted = acc;
        #1;
        compare();
    endtask

    // Offer a word until taken (bounded). in_valid is left high on return.
    task automatic send_word(input logic [W-1:0] w, input bit allow_drop);
        bit got;
        got = 1'b0;
        in_data = w;
        for (int k = 0; k < 40; k++) begin
            in_valid = allow_drop ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
            if (accepted) begin
                got = 1'b1;
                break;
            end
        end
        in_valid = 1'b1;
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL accept_timeout observed=%b expected=1", got);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        accepted = 1'b0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset state
        #1;
        compare();
        #11;
        compare();
        rst = 1'b1;
        idle(2);

        // Single word, then idle
        send_word(4'b1011, 1'b0);
        idle(7);

        // Back-to-back words with valid held high
        send_word(4'b0101, 1'b0);
        send_word(4'b1011, 1'b0);
        idle(7);

        // Stall: second word waits for the last bit of the first
        send_word(4'b0001, 1'b0);
        send_word(4'b1110, 1'b0);
        idle(7);

        // Asymmetric word for bit order
        send_word(4'b1101, 1'b0);
        idle(7);

        // Parity-sensitive pair
        send_word(4'b1011, 1'b0);
        send_word(4'b1001, 1'b0);
        idle(7);

        // Async reset between edges, two bits into a word
        send_word(4'b1011, 1'b0);
        in_valid = 1'b0;
        step();
        #2;
        rst = 1'b0;
        #1;
        qm.delete();
        ql.delete();
        compare();
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        idle(2);
        send_word(4'b1011, 1'b0);
        idle(7);

        // Randomized traffic with gaps and withdrawn offers
        for (int n = 0; n < 150; n++) begin
            logic [W-1:0] w;
            w = W'($urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            send_word(w, 1'b1);
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
